// File: rtl/key_led_ctrl_if.sv
// key_led_ctrl_if: user I/O bundle between the board pins and key_led_ctrl.
//
// Signals:
//   key        raw asynchronous key levels, 1 = pressed
//   brightness LED duty level 0..7 (only used when LED_PWM_EN is defined)
//   key_level  debounced key levels
//   key_press  one-cycle pulse on each debounced 0->1 transition
//   led_mode   current pattern mode (0 blink, 1 walk up, 2 walk down, 3 bounce)
//   paused     1 = pattern stepping frozen
//   usr_led    registered LED drive, 1 = on
//
// Modports: master drives the raw inputs (board / bench side), slave is the controller.
interface key_led_ctrl_if #(
    parameter int unsigned NUM_KEYS = 2,
    parameter int unsigned NUM_LEDS = 4
);
    logic [NUM_KEYS-1:0] key;
    logic [2:0]          brightness;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [1:0]          led_mode;
    logic                paused;
    logic [NUM_LEDS-1:0] usr_led;

    modport master (
        output key, brightness,
        input  key_level, key_press, led_mode, paused, usr_led
    );

    modport slave (
        input  key, brightness,
        output key_level, key_press, led_mode, paused, usr_led
    );
endinterface

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: key debouncer and 4-mode LED pattern engine for board user I/O.
//
// Ports:
//   clk_50m  50 MHz board clock
//   rst      synchronous reset, active-high
//   ctrl_io  key_led_ctrl_if.slave: raw keys and brightness in; debounced levels,
//            press pulses, mode, pause flag and LED drive out
//
// Key 0 press steps the mode forward, key 1 press steps it back (both together: no
// change). Holding key 0 for HOLD_CYCLES toggles pause.
//
// Optional feature: define LED_PWM_EN to gate the LEDs with a 3-bit PWM driven by
// brightness. Without it brightness is ignored.
module key_led_ctrl #(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned NUM_LEDS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8192,
    parameter int unsigned STEP_CYCLES     = 67108864,
    parameter int unsigned HOLD_CYCLES     = 100000000
) (
    input  logic          clk_50m,
    input  logic          rst,
    key_led_ctrl_if.slave ctrl_io
);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned STEP_W = $clog2(STEP_CYCLES) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned POS_W  = $clog2(NUM_LEDS);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        ModeBlink    = 2'd0,
        ModeWalkUp   = 2'd1,
        ModeWalkDown = 2'd2,
        ModeBounce   = 2'd3
    } mode_e;

    // ---------------- synchroniser + debounce ----------------
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];
    logic [DB_W-1:0]     db_cnt_d [NUM_KEYS];

    always_comb begin
        level_d = level_q;
        press_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= ctrl_io.key;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < NUM_KEYS; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // ---------------- mode, pause and pattern engine ----------------
    mode_e               mode_q, mode_d;
    logic                mode_chg;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                paused_q, paused_d;
    logic [STEP_W-1:0]   presc_q, presc_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                phase_q, phase_d;
    logic                dir_q, dir_d;     // 0 = up, 1 = down
    logic                step_tick;
    logic [NUM_LEDS-1:0] pattern, led_d, led_q;

    always_comb begin
        mode_d = mode_q;
        case (press_q[1:0])
            2'b01:   mode_d = mode_e'(mode_q + 2'd1);
            2'b10:   mode_d = mode_e'(mode_q - 2'd1);
            default: mode_d = mode_q;
        endcase
        mode_chg = (mode_d != mode_q);
    end

    // Hold counter saturates, so the toggle fires once per hold.
    always_comb begin
        hold_d   = hold_q;
        paused_d = paused_q;
        if (!level_q[0]) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
            if (hold_d == HOLD_LAST) paused_d = ~paused_q;
        end
    end

    always_comb begin
        step_tick = (presc_q == STEP_LAST) && !paused_q;
        presc_d   = presc_q;
        pos_d     = pos_q;
        phase_d   = phase_q;
        dir_d     = dir_q;
        if (mode_chg) begin
            // Restart the new pattern from its first position.
            presc_d = '0;
            phase_d = 1'b0;
            dir_d   = 1'b0;
            pos_d   = (mode_d == ModeWalkDown) ? POS_MAX : '0;
        end else if (!paused_q) begin
            presc_d = (presc_q == STEP_LAST) ? '0 : presc_q + 1'b1;
            if (step_tick) begin
                unique case (mode_q)
                    ModeBlink:    phase_d = ~phase_q;
                    ModeWalkUp:   pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                    ModeWalkDown: pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
                    ModeBounce: begin
                        // Reverse at the ends without dwelling on the end LED.
                        if (!dir_q) begin
                            if (pos_q == POS_MAX) begin
                                dir_d = 1'b1;
                                pos_d = pos_q - 1'b1;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b0;
                                pos_d = pos_q + 1'b1;
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        pattern = '0;
        if (mode_q == ModeBlink) pattern = {NUM_LEDS{phase_q}};
        else                     pattern[pos_q] = 1'b1;
    end

`ifdef LED_PWM_EN
    logic [2:0] pwm_cnt_q;

    always_ff @(posedge clk_50m) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_q + 3'd1;
    end

    assign led_d = pattern & {NUM_LEDS{pwm_cnt_q < ctrl_io.brightness}};
`else
    logic unused_brightness;
    assign unused_brightness = ^ctrl_io.brightness;
    assign led_d = pattern;
`endif

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            mode_q   <= ModeBlink;
            hold_q   <= '0;
            paused_q <= 1'b0;
            presc_q  <= '0;
            pos_q    <= '0;
            phase_q  <= 1'b0;
            dir_q    <= 1'b0;
            led_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            hold_q   <= hold_d;
            paused_q <= paused_d;
            presc_q  <= presc_d;
            pos_q    <= pos_d;
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
        end
    end

    assign ctrl_io.key_level = level_q;
    assign ctrl_io.key_press = press_q;
    assign ctrl_io.led_mode  = mode_q;
    assign ctrl_io.paused    = paused_q;
    assign ctrl_io.usr_led   = led_q;
endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: self-checking bench for key_led_ctrl with small timing parameters.
// Fixed vector table plus hand sequences for glitch, pause and reset, then random key
// activity; a behavioural model is compared against the DUT every cycle.
module tb_key_led_ctrl;
    localparam int DB   = 4;
    localparam int STEP = 8;
    localparam int HOLD = 20;
    localparam int NL   = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_total;
    int   n_pass;

    always #10 clk = ~clk;

    key_led_ctrl_if #(.NUM_KEYS(2), .NUM_LEDS(NL)) io ();

    key_led_ctrl #(
        .NUM_KEYS(2),
        .NUM_LEDS(NL),
        .DEBOUNCE_CYCLES(DB),
        .STEP_CYCLES(STEP),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_50m(clk),
        .rst(rst),
        .ctrl_io(io)
    );

    // ---------------- behavioural model ----------------
    logic [1:0] m_s1, m_s2, m_lvl, m_press, m_mode;
    logic       m_paused;
    logic [3:0] m_led;
    int         m_run [2];   // consecutive cycles the synced key differed from its level
    int         m_hold;      // consecutive cycles key 0 has been debounced-high
    int         m_ticks;     // unpaused cycles since the pattern last restarted

    // Pattern from the number of completed steps since the restart.
    function automatic logic [3:0] m_pattern(logic [1:0] mode, int ticks);
        int n;
        int p;
        logic [3:0] r;
        n = ticks / STEP;
        r = '0;
        case (mode)
            2'd0:    r = (n % 2 == 1) ? 4'hF : 4'h0;
            2'd1:    r[n % NL] = 1'b1;
            2'd2:    r[NL - 1 - n % NL] = 1'b1;
            default: begin
                p = n % (2 * NL - 2);
                r[(p < NL) ? p : 2 * NL - 2 - p] = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic model_edge();
        logic [1:0] n_lvl, n_press, n_mode;
        logic       n_paused;
        logic [3:0] n_led;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_mode = '0;
            m_paused = 1'b0; m_led = '0; m_run[0] = 0; m_run[1] = 0;
            m_hold = 0; m_ticks = 0;
        end else begin
            n_lvl   = m_lvl;
            n_press = '0;
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        n_lvl[i]   = m_s2[i];
                        n_press[i] = m_s2[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            n_led  = m_pattern(m_mode, m_ticks);
            n_mode = m_mode;
            if (m_press == 2'b01)      n_mode = m_mode + 2'd1;
            else if (m_press == 2'b10) n_mode = m_mode - 2'd1;
            n_paused = m_paused;
            if (m_lvl[0]) begin
                if (m_hold < HOLD) begin
                    m_hold++;
                    if (m_hold == HOLD - 1) n_paused = ~m_paused;
                end
            end else begin
                m_hold = 0;
            end
            if (n_mode != m_mode) m_ticks = 0;
            else if (!m_paused)   m_ticks++;
            m_s2 = m_s1;
            m_s1 = io.key;
            m_lvl = n_lvl; m_press = n_press; m_mode = n_mode;
            m_paused = n_paused; m_led = n_led;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", {io.key_level, io.key_press, io.led_mode, io.paused, io.usr_led},
              {m_lvl, m_press, m_mode, m_paused, m_led});
    endtask

    task automatic run(logic [1:0] k, int n);
        io.key = k;
        repeat (n) tick();
    endtask

    typedef struct {
        logic [1:0] key;
        int         n;
        logic [1:0] mode;
        logic [1:0] level;
        logic [1:0] press;
        logic       chk_led;
        logic [3:0] led;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(logic [1:0] k, int n, logic [1:0] m, logic [1:0] l,
                                    logic [1:0] p, logic c, logic [3:0] led);
        vec_t v;
        v.key = k; v.n = n; v.mode = m; v.level = l; v.press = p; v.chk_led = c; v.led = led;
        tbl.push_back(v);
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        io.key = '0;
        io.brightness = '0;
        repeat (3) tick();
        check("rst_level", io.key_level, 0);
        check("rst_press", io.key_press, 0);
        check("rst_mode", io.led_mode, 0);
        check("rst_paused", io.paused, 0);
        check("rst_led", io.usr_led, 0);
        rst = 1'b0;

        // key, cycles, mode, level, press, check led, led
        add_vec(2'b00,  8, 0, 2'b00, 2'b00, 1, 4'h0);  // blink starts dark
        add_vec(2'b00,  1, 0, 2'b00, 2'b00, 1, 4'hF);
        add_vec(2'b00,  7, 0, 2'b00, 2'b00, 1, 4'hF);
        add_vec(2'b00,  1, 0, 2'b00, 2'b00, 1, 4'h0);
        add_vec(2'b00, 23, 0, 2'b00, 2'b00, 1, 4'h0);
        add_vec(2'b01,  3, 0, 2'b00, 2'b00, 1, 4'hF);  // 3-cycle glitch
        add_vec(2'b00, 10, 0, 2'b00, 2'b00, 1, 4'h0);
        add_vec(2'b01,  5, 0, 2'b00, 2'b00, 1, 4'hF);
        add_vec(2'b01,  1, 0, 2'b01, 2'b01, 1, 4'hF);  // level rises 6 edges after key
        add_vec(2'b01,  1, 1, 2'b01, 2'b00, 1, 4'hF);
        add_vec(2'b01,  1, 1, 2'b01, 2'b00, 1, 4'h1);
        add_vec(2'b01,  2, 1, 2'b01, 2'b00, 1, 4'h1);
        add_vec(2'b00,  6, 1, 2'b00, 2'b00, 1, 4'h2);
        add_vec(2'b10,  8, 0, 2'b10, 2'b00, 0, 4'h0);
        add_vec(2'b00,  8, 0, 2'b00, 2'b00, 0, 4'h0);
        add_vec(2'b10,  8, 3, 2'b10, 2'b00, 0, 4'h0);
        add_vec(2'b00,  8, 3, 2'b00, 2'b00, 0, 4'h0);
        add_vec(2'b10,  8, 2, 2'b10, 2'b00, 0, 4'h0);
        add_vec(2'b00,  8, 2, 2'b00, 2'b00, 0, 4'h0);
        add_vec(2'b10,  8, 1, 2'b10, 2'b00, 0, 4'h0);
        add_vec(2'b00,  8, 1, 2'b00, 2'b00, 0, 4'h0);
        add_vec(2'b10,  8, 0, 2'b10, 2'b00, 0, 4'h0);
        add_vec(2'b00,  8, 0, 2'b00, 2'b00, 0, 4'h0);
        add_vec(2'b11,  6, 0, 2'b11, 2'b11, 0, 4'h0);  // simultaneous presses
        add_vec(2'b11,  2, 0, 2'b11, 2'b00, 0, 4'h0);
        add_vec(2'b00,  8, 0, 2'b00, 2'b00, 0, 4'h0);
        add_vec(2'b10,  7, 3, 2'b10, 2'b00, 0, 4'h0);  // into bounce
        add_vec(2'b00,  1, 3, 2'b10, 2'b00, 1, 4'h1);
        add_vec(2'b00,  8, 3, 2'b00, 2'b00, 1, 4'h2);
        add_vec(2'b00,  8, 3, 2'b00, 2'b00, 1, 4'h4);
        add_vec(2'b00,  8, 3, 2'b00, 2'b00, 1, 4'h8);
        add_vec(2'b00,  8, 3, 2'b00, 2'b00, 1, 4'h4);
        add_vec(2'b00,  8, 3, 2'b00, 2'b00, 1, 4'h2);
        add_vec(2'b00,  8, 3, 2'b00, 2'b00, 1, 4'h1);
        add_vec(2'b00,  8, 3, 2'b00, 2'b00, 1, 4'h2);
        add_vec(2'b01,  8, 0, 2'b01, 2'b00, 0, 4'h0);
        add_vec(2'b00,  8, 0, 2'b00, 2'b00, 0, 4'h0);
        add_vec(2'b01,  8, 1, 2'b01, 2'b00, 0, 4'h0);
        add_vec(2'b00,  8, 1, 2'b00, 2'b00, 0, 4'h0);

        foreach (tbl[i]) begin
            run(tbl[i].key, tbl[i].n);
            check($sformatf("vec%0d_mode", i), io.led_mode, tbl[i].mode);
            check($sformatf("vec%0d_level", i), io.key_level, tbl[i].level);
            check($sformatf("vec%0d_press", i), io.key_press, tbl[i].press);
            if (tbl[i].chk_led) check($sformatf("vec%0d_led", i), io.usr_led, tbl[i].led);
        end

        // Long hold on key 0 in walk-up: mode advances, then pause after the hold.
        run(2'b01, 24);
        check("hold1_not_yet", io.paused, 0);
        run(2'b01, 1);
        check("hold1_paused", io.paused, 1);
        run(2'b01, 15);
        check("hold1_mode", io.led_mode, 2);
        check("hold1_led", io.usr_led, 4'h2);
        run(2'b00, 10);
        check("rel1_paused", io.paused, 1);
        check("rel1_led_frozen", io.usr_led, 4'h2);
        run(2'b01, 24);
        check("hold2_still_paused", io.paused, 1);
        check("hold2_mode", io.led_mode, 3);
        check("hold2_led", io.usr_led, 4'h1);
        run(2'b01, 6);
        check("hold2_unpaused", io.paused, 0);
        run(2'b00, 10);
        check("resume_led", io.usr_led, 4'h2);

        // Reset while key 0 is held: key must be debounced again from scratch.
        run(2'b01, 12);
        rst = 1'b1;
        tick();
        check("midrst_level", io.key_level, 0);
        check("midrst_press", io.key_press, 0);
        check("midrst_mode", io.led_mode, 0);
        check("midrst_paused", io.paused, 0);
        check("midrst_led", io.usr_led, 0);
        rst = 1'b0;
        run(2'b01, 5);
        check("redb_level_low", io.key_level, 0);
        run(2'b01, 1);
        check("redb_level", io.key_level, 2'b01);
        check("redb_press", io.key_press, 2'b01);
        run(2'b01, 1);
        check("redb_mode", io.led_mode, 1);
        check("redb_press_once", io.key_press, 0);
        run(2'b00, 10);

        // Random key activity, occasional reset; the model is compared every cycle.
        for (int s = 0; s < 120; s++) begin
            io.brightness = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            run(2'($urandom_range(0, 3)), $urandom_range(1, 30));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/key_led_ctrl.md
Name: key_led_ctrl

Overview:
Parametrised key-debounce and LED-pattern controller for board user I/O. It debounces NUM_KEYS raw push-buttons and emits clean press pulses. Key presses step a 4-mode LED pattern engine (blink, walk up, walk down, bounce) driving NUM_LEDS user LEDs. A long hold on key 0 toggles pause. It sits at top level beside the processing-system wrapper, clocked by the 50 MHz board clock.

Parameters:
NUM_KEYS, 2, number of raw key inputs (>=2; only keys 0 and 1 control modes)
NUM_LEDS, 4, number of LED outputs (>=2)
DEBOUNCE_CYCLES, 8192, cycles a synchronised key must hold its new level before the debounced level changes
STEP_CYCLES, 67108864, cycles per pattern step (>=2)
HOLD_CYCLES, 100000000, cycles key 0 must stay debounced-high to toggle pause

Ports:
clk_50m  in  1  system clock
rst  in  1  synchronous reset, active-high
key  in  NUM_KEYS  raw asynchronous key levels, 1 = pressed
brightness  in  3  LED duty level, 0..7 (used only with LED_PWM_EN)
key_level  out  NUM_KEYS  debounced key levels
key_press  out  NUM_KEYS  one-cycle pulse on each debounced 0->1 transition
led_mode  out  2  current mode: 0 BLINK, 1 WALK_UP, 2 WALK_DOWN, 3 BOUNCE
paused  out  1  1 = pattern stepping frozen
usr_led  out  NUM_LEDS  registered LED drive, 1 = on

Behaviour:
- Reset values: key_level=0, key_press=0, led_mode=0, paused=0, usr_led=0. Also reset: sync flops, debounce counters, prescaler, pos=0, phase=0, dir=up, hold counter.
- Reset mid-operation: all state returns to reset values on the next edge. A key still held after reset must be fully re-debounced and then produces a fresh key_press.
- Synchroniser: each key passes through 2 flops. The debounce logic sees only the synchronised value.
- Debounce, per key: counter clears whenever the synchronised value equals key_level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, key_level flips and the counter clears. Press and release are both debounced.
- Debounce latency: a clean step on key is reflected in key_level 2+DEBOUNCE_CYCLES edges later.
- A glitch shorter than DEBOUNCE_CYCLES causes no change.
- key_press[i] is high in exactly the cycle key_level[i] first reads 1. It never repeats while the key is held.
- Mode control, evaluated on key_press:
  - key_press[0] alone: led_mode+1 mod 4.
  - key_press[1] alone: led_mode-1 mod 4.
  - Both in the same cycle: no change.
  - Keys >=2 do not affect mode.
  - The mode register updates on the edge after key_press.
- Mode change restarts the pattern at that same edge: prescaler=0, phase=0, dir=up. pos=NUM_LEDS-1 for WALK_DOWN; pos=0 otherwise.
- Pause:
  - The hold counter increments while key_level[0]=1 and saturates at HOLD_CYCLES.
  - paused toggles once, on the edge where the counter reaches HOLD_CYCLES-1.
  - The counter clears when key_level[0]=0.
  - The key_press[0] that started the hold has already advanced the mode; this is intended.
- Prescaler: counts 0..STEP_CYCLES-1 and wraps. step_tick is asserted when it equals STEP_CYCLES-1 and paused=0. While paused, the prescaler holds.
- On step_tick:
  - BLINK: phase toggles.
  - WALK_UP: pos+1, wrapping NUM_LEDS-1 -> 0.
  - WALK_DOWN: pos-1, wrapping 0 -> NUM_LEDS-1.
  - BOUNCE: pos moves in dir. When up and pos=NUM_LEDS-1, dir becomes down and pos becomes NUM_LEDS-2 in the same step. Symmetric at pos=0. Sequence for NUM_LEDS=4: 0,1,2,3,2,1,0,1...
- Pattern: BLINK gives all bits = phase. Modes 1-3 give a one-hot at bit pos.
- usr_led is registered from the pattern: a pos/phase/mode change is visible on usr_led one edge later.
- Widths: counters are sized with $clog2 of their terminal value plus 1. There is no overflow; all counters saturate or wrap as stated.

Optional Feature:
LED_PWM_EN:
- Defined: a free-running 3-bit pwm_cnt (reset 0) increments every cycle. usr_led = pattern & {NUM_LEDS{pwm_cnt < brightness}}, still registered. brightness=0 forces all LEDs off. brightness=7 gives 7/8 duty.
- Not defined: the brightness input is ignored and there is no pwm_cnt; usr_led = pattern.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, STEP_CYCLES=8, HOLD_CYCLES=20, NUM_LEDS=4, NUM_KEYS=2.
1. Reset, then no keys for 40 cycles -> led_mode=0. usr_led toggles between 0000 and 1111 every 8 cycles, starting at 0000. key_press=0.
2. key[0] high for 3 cycles, then low -> key_level and key_press remain 0. A subsequent 10-cycle press -> key_level[0] rises 6 edges after key rises; key_press[0] pulses once; led_mode=1 next edge; usr_led=0001 one edge later, then 0010 after 8 cycles.
3. Four separate key[1] presses from mode 0 -> led_mode sequence 3,2,1,0. key[0] and key[1] pressed on the same cycle -> mode unchanged, both key_press bits pulse.
4. Mode 3 run for 7 steps -> pos 0,1,2,3,2,1,0,1 (usr_led 0001,0010,0100,1000,0100,0010,0001,0010).
5. key[0] held for 40 cycles in mode 1 -> mode becomes 2 and paused=1 after 20 debounced-high cycles; usr_led frozen. Release and hold again -> paused=0 and stepping resumes from the frozen pos.
6. Assert rst while key[0] is held mid-pattern -> all outputs 0. Key released by debounce state, then re-pressed after 6 edges -> key_press[0] pulses and mode becomes 1.
7. (LED_PWM_EN only) brightness=2, mode 0 with phase=1 -> usr_led=1111 for 2 of every 8 cycles. brightness=0 -> usr_led=0000.
